// File: rtl/phy_tx_pkg.sv
// Shared constants and helpers for the striped PHY transmitter.
// No logic: symbol defaults and a counter-width helper only.
// No handshake: nothing here carries backpressure.
package phy_tx_pkg;

  localparam logic [7:0] IDLE_DEF = 8'h7C;
  localparam logic [7:0] COM_DEF  = 8'hBC;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/phy_tx_serializer.sv
// One lane shifter: parallel-loads a symbol and shifts it out MSB first.
// Latency: the loaded MSB appears on msb the cycle after the load edge.
// No backpressure: load and shift are issued by the top-level bit counter.
module phy_tx_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_8f,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             shift,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next shift-register value: clear when idle, load at a slot boundary, else shift.
  always_comb begin
    sr_d = sr_q;
    if (!enable) begin
      sr_d = '0;
    end else if (load) begin
      sr_d = load_word;
    end else if (shift) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  // Shift-register state; reset drops the partial symbol immediately.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/phy_tx_striped.sv
// Multi-lane PHY transmitter: stripes a word stream round-robin over LANES serial lanes (COM insertion under PHY_TX_COM_EN).
// Latency: last word of a stripe reaches tx_out 1..WIDTH cycles after acceptance (plus one slot when a COM intervenes).
// Backpressure: ready_out drops once a full stripe is staged and recovers at the boundary that launches it.
module phy_tx_striped
  import phy_tx_pkg::*;
#(
  parameter int unsigned      LANES      = 2,
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE       = WIDTH'(IDLE_DEF),
  parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_DEF),
  parameter int unsigned      COM_PERIOD = 16
) (
  input  logic             clk_8f,
  input  logic             reset_L,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [LANES-1:0] tx_out,
  output logic             word_start,
  output logic             sym_is_data
);

  localparam int unsigned CW = cnt_w(WIDTH);
  localparam int unsigned FW = cnt_w(LANES + 1);

  // Parameter sanity, caught at elaboration.
  if (LANES < 1) begin : g_chk_lanes
    $error("phy_tx_striped: LANES must be >= 1");
  end
  if (WIDTH < 2) begin : g_chk_width
    $error("phy_tx_striped: WIDTH must be >= 2");
  end
  if (COM_PERIOD < 2) begin : g_chk_period
    $error("phy_tx_striped: COM_PERIOD must be >= 2");
  end
  if (COM == IDLE) begin : g_chk_com
    $warning("phy_tx_striped: COM equals IDLE, alignment symbol is indistinguishable");
  end

  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [WIDTH-1:0] staging_q [LANES];
  logic [WIDTH-1:0] staging_d [LANES];
  logic             word_start_q, word_start_d;
  logic             sym_is_data_q, sym_is_data_d;

  logic             boundary;
  logic             load_edge;
  logic             shift_en;
  logic             com_slot;
  logic             load_data;
  logic             accept;
  logic [WIDTH-1:0] lane_word [LANES];

`ifdef PHY_TX_COM_EN
  localparam int unsigned SW = cnt_w(COM_PERIOD);
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;

  // Slot counter: parked on the last slot while disabled so the first slot out is COM.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    if (!enable) begin
      slot_cnt_d = SW'(COM_PERIOD - 1);
    end else if (boundary) begin
      slot_cnt_d = (slot_cnt_q == SW'(COM_PERIOD - 1)) ? '0 : slot_cnt_q + SW'(1);
    end
  end

  // Slot counter register.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      slot_cnt_q <= SW'(COM_PERIOD - 1);
    end else begin
      slot_cnt_q <= slot_cnt_d;
    end
  end

  assign com_slot = (slot_cnt_q == SW'(COM_PERIOD - 1));
`else
  assign com_slot = 1'b0;
`endif

  assign boundary  = (bit_cnt_q == CW'(WIDTH - 1));
  assign load_edge = enable && boundary;
  assign shift_en  = enable && !boundary;
  // A stripe only launches when complete, so lanes never carry a partial stripe.
  assign load_data = load_edge && !com_slot && (fill_cnt_q == FW'(LANES));
  assign ready_out = enable && (fill_cnt_q < FW'(LANES));
  assign accept    = valid_in && ready_out;

  // Per-lane symbol for the next slot: COM, the staged stripe, or IDLE.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_word[i] = IDLE;
      if (com_slot) begin
        lane_word[i] = COM;
      end else if (load_data) begin
        lane_word[i] = staging_q[i];
      end
    end
  end

  // Bit counter, stripe staging and slot flags.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    fill_cnt_d    = fill_cnt_q;
    word_start_d  = 1'b0;
    sym_is_data_d = sym_is_data_q;
    for (int i = 0; i < LANES; i++) begin
      staging_d[i] = staging_q[i];
    end
    if (!enable) begin
      // Park just before a boundary so re-enable starts a fresh slot.
      bit_cnt_d     = CW'(WIDTH - 1);
      sym_is_data_d = 1'b0;
    end else begin
      bit_cnt_d    = boundary ? '0 : bit_cnt_q + CW'(1);
      word_start_d = boundary;
      if (boundary) begin
        sym_is_data_d = load_data;
      end
      // accept cannot coincide with load_data: ready_out is low when the stripe is full.
      if (load_data) begin
        fill_cnt_d = '0;
      end else if (accept) begin
        fill_cnt_d = fill_cnt_q + FW'(1);
      end
      for (int i = 0; i < LANES; i++) begin
        if (accept && (fill_cnt_q == FW'(i))) begin
          staging_d[i] = data_in;
        end
      end
    end
  end

  // Control and staging registers; reset discards any staged words.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_q     <= CW'(WIDTH - 1);
      fill_cnt_q    <= '0;
      word_start_q  <= 1'b0;
      sym_is_data_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        staging_q[i] <= '0;
      end
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      fill_cnt_q    <= fill_cnt_d;
      word_start_q  <= word_start_d;
      sym_is_data_q <= sym_is_data_d;
      for (int i = 0; i < LANES; i++) begin
        staging_q[i] <= staging_d[i];
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    phy_tx_serializer #(
      .WIDTH(WIDTH)
    ) u_ser (
      .clk_8f   (clk_8f),
      .reset_L  (reset_L),
      .enable   (enable),
      .load     (load_edge),
      .load_word(lane_word[i]),
      .shift    (shift_en),
      .msb      (tx_out[i])
    );
  end

  assign word_start  = word_start_q;
  assign sym_is_data = sym_is_data_q;

endmodule
